// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds x/y/de from hsync/vsync, measures
// line and frame totals, and locks once two consecutive frames agree.
module vga_sync_decoder #(
  parameter int unsigned H_W       = 12,
  parameter int unsigned V_W       = 11,
  parameter bit          HSYNC_NEG = 1'b1,
  parameter bit          VSYNC_NEG = 1'b1,
  parameter int unsigned H_OFS     = 144,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_OFS     = 35,
  parameter int unsigned V_ACTIVE  = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic [2:0]     pixel_in,
  output logic [2:0]     pixel_out,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           frame_start,
  output logic           locked,
  output logic [H_W-1:0] h_total,
  output logic [V_W-1:0] v_total
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [H_W-1:0] H_MAX = {H_W{1'b1}};
  localparam logic [V_W-1:0] V_MAX = {V_W{1'b1}};
  localparam logic [H_W-1:0] H_LO  = H_W'(H_OFS);
  localparam logic [H_W-1:0] H_HI  = H_W'(H_OFS + H_ACTIVE);
  localparam logic [V_W-1:0] V_LO  = V_W'(V_OFS);
  localparam logic [V_W-1:0] V_HI  = V_W'(V_OFS + V_ACTIVE);

  state_t         state, state_next;
  logic           hs_r, vs_r, hs_a_d, vs_edge, acq_ok;
  logic [2:0]     px_r;
  logic [H_W-1:0] h_cnt, ref_h, h_inc, h_cnt_next;
  logic [V_W-1:0] v_cnt, ref_v, v_inc, v_cnt_next;
  logic           hs_a, vs_a, hs_rise, frame_edge, h_bad, v_bad, h_sat, de_c;

  // Normalise polarity and find the line / frame edges on the registered samples.
  assign hs_a       = hs_r ^ HSYNC_NEG;
  assign vs_a       = vs_r ^ VSYNC_NEG;
  assign hs_rise    = hs_a & ~hs_a_d;
  assign frame_edge = hs_rise & vs_a & ~vs_edge;

  assign h_inc      = (h_cnt == H_MAX) ? H_MAX : h_cnt + H_W'(1);
  assign v_inc      = (v_cnt == V_MAX) ? V_MAX : v_cnt + V_W'(1);
  assign h_cnt_next = hs_rise ? '0 : h_inc;
  assign v_cnt_next = frame_edge ? '0 : (hs_rise ? v_inc : v_cnt);

  // h_inc at a line edge is the period of the line that just ended.
  assign h_bad = hs_rise & (h_inc != ref_h);
  assign v_bad = frame_edge & (v_inc != ref_v);
  assign h_sat = (h_cnt_next == H_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (frame_edge) state_next = ACQUIRE;
      ACQUIRE: if (frame_edge && acq_ok && !h_bad) state_next = LOCKED;
      LOCKED:  if (h_bad || v_bad || h_sat) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  assign de_c = (state_next == LOCKED) &&
                (h_cnt_next >= H_LO) && (h_cnt_next < H_HI) &&
                (v_cnt_next >= V_LO) && (v_cnt_next < V_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r        <= HSYNC_NEG;
      vs_r        <= VSYNC_NEG;
      px_r        <= '0;
      hs_a_d      <= 1'b0;
      vs_edge     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      ref_h       <= '0;
      ref_v       <= '0;
      acq_ok      <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      locked      <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel_out   <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_r   <= hsync_in;
      vs_r   <= vsync_in;
      px_r   <= pixel_in;
      hs_a_d <= hs_a;
      h_cnt  <= h_cnt_next;
      v_cnt  <= v_cnt_next;
      if (hs_rise) begin
        h_total <= h_inc;
        vs_edge <= vs_a;
      end
      if (frame_edge) v_total <= v_inc;
      // Each unlocked frame edge starts a fresh acquisition window.
      if (frame_edge && state != LOCKED) begin
        ref_h  <= h_inc;
        acq_ok <= 1'b1;
      end else if (h_bad) begin
        acq_ok <= 1'b0;
      end
      if (state == ACQUIRE && state_next == LOCKED) ref_v <= v_inc;
      locked      <= (state_next == LOCKED);
      de          <= de_c;
      x           <= de_c ? h_cnt_next - H_LO : '0;
      y           <= de_c ? v_cnt_next - V_LO : '0;
      pixel_out   <= de_c ? px_r : 3'd0;
      frame_start <= de_c && (h_cnt_next == H_LO) && (v_cnt_next == V_LO);
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced 40x20 raster with random pixels and sync faults,
// checked cycle by cycle against an edge-time based reference model.
module tb_vga_sync_decoder;
  localparam int unsigned H_W = 12, V_W = 11;
  localparam int H_OFS = 10, H_ACTIVE = 24, V_OFS = 3, V_ACTIVE = 12;
  localparam int H_TOT = 40, V_TOT = 20, HS_W = 4, VS_L = 2, H_SAT = 4095;
  localparam int DE_PER_FRAME = H_ACTIVE * V_ACTIVE;

  logic clk = 1'b0, rst = 1'b1, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [2:0] pixel_in = 3'd0, pixel_out;
  logic de, frame_start, locked;
  logic [H_W-1:0] x, h_total;
  logic [V_W-1:0] y, v_total;

  vga_sync_decoder #(.H_W(H_W), .V_W(V_W), .HSYNC_NEG(1'b1), .VSYNC_NEG(1'b1),
    .H_OFS(H_OFS), .H_ACTIVE(H_ACTIVE), .V_OFS(V_OFS), .V_ACTIVE(V_ACTIVE)) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_in(pixel_in),
    .pixel_out(pixel_out), .de(de), .x(x), .y(y), .frame_start(frame_start),
    .locked(locked), .h_total(h_total), .v_total(v_total));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] px; logic de; logic [H_W-1:0] x; logic [V_W-1:0] y;
    logic fs; logic lk; logic [V_W-1:0] vt;
  } obs_t;
  typedef struct { obs_t o; logic [H_W-1:0] ht; bit hk; } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
  int de_acc = 0, fs_acc = 0, last_fs_cyc = -1, pat_bad = 0;
  bit pat_on = 1'b0;

  // Reference model state: times of line edges, lines since frame edge, lock mode.
  bit m_prev_hs, m_vs_edge, m_hk;
  int m_last_edge, m_line, m_mode, m_refh, m_refv, m_ht, m_vt, m_t;
  int m_periods[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > H_SAT) ? H_SAT : v;
  endfunction

  task automatic model_reset();
    m_prev_hs = 1'b0; m_vs_edge = 1'b0; m_last_edge = -1; m_line = 0; m_mode = 0;
    m_refh = -1; m_refv = -1; m_ht = 0; m_hk = 1'b1; m_vt = 0; m_t = 0;
    m_periods.delete();
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [2:0] px, output exp_t e);
    bit hs_a, vs_a, rise, frame, all_ok, lk, de_e;
    int period, pos, vtot;
    hs_a = ~hs; vs_a = ~vs; period = -1; vtot = 0; frame = 1'b0;
    rise = hs_a && !m_prev_hs;
    m_prev_hs = hs_a;
    if (rise) begin
      period = (m_last_edge < 0) ? -1 : sat(m_t - m_last_edge);
      m_last_edge = m_t;
      m_ht = period; m_hk = (period >= 0);
      frame = vs_a && !m_vs_edge;
      m_vs_edge = vs_a;
      if (frame) begin vtot = m_line + 1; m_vt = vtot; m_line = 0; end
      else m_line++;
    end
    pos = (m_last_edge < 0) ? -1 : sat(m_t - m_last_edge);
    if (m_mode == 2) begin
      if ((rise && period != m_refh) || (frame && vtot != m_refv) || pos == H_SAT) m_mode = 0;
    end else if (frame) begin
      all_ok = (m_mode == 1) && (period == m_refh);
      foreach (m_periods[i]) if (m_periods[i] != m_refh) all_ok = 1'b0;
      if (all_ok) begin m_mode = 2; m_refv = vtot; end
      else begin m_mode = 1; m_refh = period; end
      m_periods.delete();
    end else if (rise && m_mode == 1) begin
      m_periods.push_back(period);
    end
    m_t++;
    lk   = (m_mode == 2);
    de_e = lk && pos >= H_OFS && pos < H_OFS + H_ACTIVE && m_line >= V_OFS && m_line < V_OFS + V_ACTIVE;
    e.o.px = de_e ? px : 3'd0;
    e.o.de = de_e;
    e.o.x  = de_e ? H_W'(pos - H_OFS) : '0;
    e.o.y  = de_e ? V_W'(m_line - V_OFS) : '0;
    e.o.fs = de_e && pos == H_OFS && m_line == V_OFS;
    e.o.lk = lk;
    e.o.vt = V_W'(m_vt);
    e.ht   = m_hk ? H_W'(m_ht) : '0;
    e.hk   = m_hk;
  endtask

  // One clock: check the output due now, then drive the next sample and predict it.
  task automatic step(input bit hs, input bit vs, input logic [2:0] px, input bit r);
    exp_t e;
    obs_t got;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      got.px = pixel_out; got.de = de; got.x = x; got.y = y;
      got.fs = frame_start; got.lk = locked; got.vt = v_total;
      chk($sformatf("cycle%0d_outputs", cyc), 64'(got), 64'(e.o));
      if (e.hk) chk($sformatf("cycle%0d_h_total", cyc), 64'(h_total), 64'(e.ht));
    end
    if (de === 1'b1) de_acc++;
    if (frame_start === 1'b1) begin fs_acc++; last_fs_cyc = cyc; end
    if (pat_on && de === 1'b1 && pixel_out !== (x[2:0] + 3'(H_OFS))) pat_bad++;
    if (pat_on && de === 1'b0 && pixel_out !== 3'd0) pat_bad++;
    if (r && !rst) q.delete();
    rst = r; hsync_in = hs; vsync_in = vs; pixel_in = px;
    if (r) begin
      model_reset();
      e.o = '0; e.ht = '0; e.hk = 1'b1;
    end else begin
      model_step(hs, vs, px, e);
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic drive_line(input bit vsa, input int len, input bit pat);
    for (int c = 0; c < len; c++)
      step(c >= HS_W, !vsa, pat ? 3'(c) : 3'($urandom), 1'b0);
  endtask

  // drop >= 0 merges that line with the next by omitting one hsync pulse.
  task automatic drive_frame(input int nlines, input int drop, input bit pat,
                             output int dcnt, output int fcnt, output int fs_ofs);
    int l3;
    l3 = -100000; de_acc = 0; fs_acc = 0; last_fs_cyc = -1;
    for (int l = 0; l < nlines; l++) begin
      if (l == V_OFS) l3 = cyc;
      if (l == drop) begin drive_line(l < VS_L, 2 * H_TOT, pat); l++; end
      else drive_line(l < VS_L, H_TOT, pat);
    end
    dcnt = de_acc; fcnt = fs_acc; fs_ofs = last_fs_cyc - l3;
  endtask

  task automatic reset_pulse();
    step(1'b1, 1'b1, 3'd0, 1'b1);
    step(1'b1, 1'b1, 3'd0, 1'b1);
    chk("reset_outputs_zero",
        64'({pixel_out, de, x, y, frame_start, locked, h_total, v_total}), 64'(0));
  endtask

  task automatic check_locked_frame(input string tag, input int d, input int f, input int o);
    chk({tag, "_locked"}, 64'(locked), 64'(1));
    chk({tag, "_de_count"}, 64'(d), 64'(DE_PER_FRAME));
    chk({tag, "_frame_start_count"}, 64'(f), 64'(1));
    chk({tag, "_frame_start_offset"}, 64'(o), 64'(H_OFS + 2));
  endtask

  initial begin
    int d, f, o, k, r;
    model_reset();
    repeat (3) step(1'b1, 1'b1, 3'd0, 1'b1);
    chk("reset_state", 64'({pixel_out, de, x, y, frame_start, locked, h_total, v_total}), 64'(0));

    // Acquisition from reset: tail lines, then two frame edges.
    for (int l = V_TOT - 3; l < V_TOT; l++) drive_line(1'b0, H_TOT, 1'b0);
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    chk("acquire_de_count", 64'(d), 64'(0));
    chk("acquire_locked", 64'(locked), 64'(0));
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    check_locked_frame("first_lock", d, f, o);
    chk("h_total", 64'(h_total), 64'(H_TOT));
    chk("v_total", 64'(v_total), 64'(V_TOT));

    // Column pattern on pixel_in.
    pat_on = 1'b1; pat_bad = 0;
    drive_frame(V_TOT, -1, 1'b1, d, f, o);
    pat_on = 1'b0;
    chk("pattern_errors", 64'(pat_bad), 64'(0));
    check_locked_frame("pattern", d, f, o);

    // Missing hsync pulse mid-frame.
    drive_frame(V_TOT, $urandom_range(4, 12), 1'b0, d, f, o);
    chk("drop_locked", 64'(locked), 64'(0));
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    chk("drop_reacquire_locked", 64'(locked), 64'(0));
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    check_locked_frame("drop_relock", d, f, o);

    // Syncs held inactive long enough to saturate the line counter.
    repeat (5000) step(1'b1, 1'b1, 3'($urandom), 1'b0);
    chk("idle_locked", 64'(locked), 64'(0));
    repeat (3) drive_frame(V_TOT, -1, 1'b0, d, f, o);
    check_locked_frame("idle_relock", d, f, o);

    // One frame with an extra line while locked.
    drive_frame(V_TOT + 1, -1, 1'b0, d, f, o);
    chk("long_frame_locked", 64'(locked), 64'(1));
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    chk("after_long_locked", 64'(locked), 64'(0));
    chk("after_long_v_total", 64'(v_total), 64'(V_TOT + 1));
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    check_locked_frame("long_relock", d, f, o);

    // Reset mid-frame while locked.
    k = $urandom_range(4, 12);
    r = $urandom_range(HS_W + 1, H_TOT - 5);
    for (int l = 0; l <= k; l++) drive_line(l < VS_L, H_TOT, 1'b0);
    for (int c = 0; c < r; c++) step(c >= HS_W, 1'b1, 3'($urandom), 1'b0);
    reset_pulse();
    for (int l = k + 2; l < V_TOT; l++) drive_line(1'b0, H_TOT, 1'b0);
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    chk("rst_acquire_locked", 64'(locked), 64'(0));
    drive_frame(V_TOT, -1, 1'b0, d, f, o);
    check_locked_frame("rst_relock", d, f, o);
    chk("rst_h_total", 64'(h_total), 64'(H_TOT));
    chk("rst_v_total", 64'(v_total), 64'(V_TOT));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
